// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch/button input conditioner.
// Board-level wrappers reuse the debounce constant and event-record widths.
package sw_debounce_pkg;

  // 1 ms at a 100 MHz system clock.
  localparam int DEBOUNCE_1MS_100MHZ = 100000;

  // Event record field widths. The channel field is sized for the largest
  // supported channel count (16); instances narrow it with chan_width().
  localparam int EV_CHAN_MAX_W = 4;
  localparam int EV_LEVEL_W    = 1;

  typedef struct packed {
    logic [EV_CHAN_MAX_W-1:0] chan;
    logic [EV_LEVEL_W-1:0]    level;
  } ev_rec_t;

  // $clog2 with a floor of one bit, so single-channel and DEBOUNCE_CYCLES=1
  // builds still get a legal vector width.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: two-flop synchronizer, debounce counter, stable level
// register and registered one-cycle rise/fall pulses.
//
// accept/accept_level flag the cycle in which the stable level is about to
// change, so the parent can set its pending bit on the same edge as
// stable/rise/fall.
module sw_debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_100MHZ,
  parameter int CNT_W           = clog2_min1(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept,
  output logic accept_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The synchronized level has disagreed with the stable level long enough.
  assign accept       = (s2 != stable) && (cnt == CNT_LAST);
  assign accept_level = s2;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Debounce counter: restarts whenever s2 matches the stable level (i.e. on
  // every bounce back), and clears again once a new level is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stable level and its edge pulses, all registered on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
      if (accept) begin
        stable <= s2;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch/button input conditioner: N debounced channels plus an event stream
// reporting each debounced change as (channel, new level).
//
// Handshake: an event transfers on a clock edge where ev_valid && ev_ready.
// Once ev_valid is high it stays high and ev_chan/ev_level hold until that
// transfer; ev_ready while ev_valid is low is ignored. ev_ready only gates
// register enables, so no output is combinational on any input.
//
// Each channel owns one pending bit and pending level. The single output
// register reloads from the lowest-index pending channel whenever it is empty
// or transferring, giving one event per cycle back to back. A change landing
// on a channel that is still pending (and not being loaded that cycle)
// overwrites the pending level and sets the sticky ev_overflow flag.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_100MHZ,
  parameter int CHAN_W          = clog2_min1(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      sw,
  output logic [N-1:0]      sw_stable,
  output logic [N-1:0]      sw_rise,
  output logic [N-1:0]      sw_fall,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CHAN_W-1:0] ev_chan,
  output logic              ev_level,
  output logic              ev_overflow
);

  logic [N-1:0] accept;
  logic [N-1:0] accept_level;

  logic [N-1:0] pending;
  logic [N-1:0] pend_level;

  logic [N-1:0] pending_nxt;
  logic [N-1:0] pend_level_nxt;
  logic [N-1:0] load_mask;

  logic              out_free;
  logic              pick_hit;
  logic [CHAN_W-1:0] pick_chan;
  logic              pick_level;
  logic              ovf_set;

  for (genvar g = 0; g < N; g++) begin : g_chan
    sw_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sw           (sw[g]),
      .stable       (sw_stable[g]),
      .rise         (sw_rise[g]),
      .fall         (sw_fall[g]),
      .accept       (accept[g]),
      .accept_level (accept_level[g])
    );
  end

  // Output register can take a new event when empty or transferring.
  assign out_free = !ev_valid || ev_ready;

  // Lowest-index pending channel; scanning downward lets the lowest win.
  always_comb begin
    pick_hit   = 1'b0;
    pick_chan  = '0;
    pick_level = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_hit   = 1'b1;
        pick_chan  = CHAN_W'(i);
        pick_level = pend_level[i];
      end
    end
  end

  // Pending bitmap update: loads clear first, then new changes set. A change
  // on a channel being loaded this cycle is a fresh pending entry, not a loss.
  always_comb begin
    pending_nxt    = pending;
    pend_level_nxt = pend_level;
    load_mask      = '0;
    ovf_set        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (out_free && pick_hit && (pick_chan == CHAN_W'(i))) begin
        load_mask[i]   = 1'b1;
        pending_nxt[i] = 1'b0;
      end
      if (accept[i]) begin
        if (pending[i] && !load_mask[i]) begin
          ovf_set = 1'b1;
        end
        pending_nxt[i]    = 1'b1;
        pend_level_nxt[i] = accept_level[i];
      end
    end
  end

  // Pending state and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pend_level  <= '0;
      ev_overflow <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      pend_level <= pend_level_nxt;
      if (ovf_set) begin
        ev_overflow <= 1'b1;
      end
    end
  end

  // Event output register; channel/level only change when a new event loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_level <= 1'b0;
    end else if (out_free) begin
      ev_valid <= pick_hit;
      if (pick_hit) begin
        ev_chan  <= pick_chan;
        ev_level <= pick_level;
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (N=4, DEBOUNCE_CYCLES=4): directed scenarios with
// literal expectations, then randomized switch/ready/reset stimulus checked
// every cycle against a behavioural model.
module tb_sw_debounce;

  localparam int N = 4;
  localparam int D = 4;
  localparam int CW = 2;
  localparam logic [D-1:0] ALL_ONES = '1;

  logic          clk;
  logic          rst;
  logic [N-1:0]  sw;
  logic [N-1:0]  sw_stable;
  logic [N-1:0]  sw_rise;
  logic [N-1:0]  sw_fall;
  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_chan;
  logic          ev_level;
  logic          ev_overflow;

  int n_run  = 0;
  int n_fail = 0;
  bit check_en = 0;
  int ev_seen = 0;

  sw_debounce #(
    .N(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .sw_stable   (sw_stable),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_chan     (ev_chan),
    .ev_level    (ev_level),
    .ev_overflow (ev_overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Level rule: the stable level flips once the last D synchronized samples
  // all show the opposite level. Events: pending bitmap + one output slot.
  logic [N-1:0]  m_s1, m_s2, m_stable, m_rise, m_fall, m_pend, m_plev;
  logic          m_valid, m_level, m_ovf;
  logic [CW-1:0] m_chan;
  logic [D-1:0]  hist [N];
  int            hfill [N];

  always @(posedge clk) begin
    logic [N-1:0] chg;
    logic [N-1:0] chg_lvl;
    int           pick;
    bit           free;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_plev = '0;
      m_valid = 1'b0; m_level = 1'b0; m_ovf = 1'b0; m_chan = '0;
      for (int i = 0; i < N; i++) begin
        hist[i] = '0;
        hfill[i] = 0;
      end
    end else begin
      chg = '0;
      chg_lvl = '0;
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][D-2:0], m_s2[i]};
        if (hfill[i] < D) hfill[i]++;
        if (hfill[i] >= D && hist[i] == (m_stable[i] ? '0 : ALL_ONES)) begin
          chg[i] = 1'b1;
          chg_lvl[i] = !m_stable[i];
        end
        m_rise[i] = chg[i] && chg_lvl[i];
        m_fall[i] = chg[i] && !chg_lvl[i];
        if (chg[i]) m_stable[i] = chg_lvl[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = sw[i];
      end
      pick = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) pick = i;
      free = !m_valid || ev_ready;
      if (free) begin
        if (pick >= 0) begin
          m_valid = 1'b1;
          m_chan = CW'(pick);
          m_level = m_plev[pick];
          m_pend[pick] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (chg[i]) begin
          if (m_pend[i]) m_ovf = 1'b1;
          m_pend[i] = 1'b1;
          m_plev[i] = chg_lvl[i];
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("stable", 32'(sw_stable), 32'(m_stable));
      chk("rise", 32'(sw_rise), 32'(m_rise));
      chk("fall", 32'(sw_fall), 32'(m_fall));
      chk("ev_valid", 32'(ev_valid), 32'(m_valid));
      chk("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
      if (m_valid) begin
        chk("ev_chan", 32'(ev_chan), 32'(m_chan));
        chk("ev_level", 32'(ev_level), 32'(m_level));
      end
      if (ev_valid === 1'b1) ev_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] target;
    rst = 1'b1;
    sw = '0;
    ev_ready = 1'b0;
    tick(1);
    check_en = 1'b1;
    tick(2);
    chk("rst_stable", 32'(sw_stable), 32'h0);
    chk("rst_valid", 32'(ev_valid), 32'h0);
    chk("rst_ovf", 32'(ev_overflow), 32'h0);
    rst = 1'b0;

    // Single rise on channel 2.
    sw = 4'b0100;
    ev_ready = 1'b1;
    tick(5);
    chk("t1_stable_e4", 32'(sw_stable), 32'h0);
    tick(1);
    chk("t1_stable_e5", 32'(sw_stable), 32'h4);
    chk("t1_rise_e5", 32'(sw_rise), 32'h4);
    tick(1);
    chk("t1_valid_e6", 32'(ev_valid), 32'h1);
    chk("t1_chan_e6", 32'(ev_chan), 32'h2);
    chk("t1_level_e6", 32'(ev_level), 32'h1);
    chk("t1_rise_e6", 32'(sw_rise), 32'h0);
    tick(1);
    chk("t1_valid_e7", 32'(ev_valid), 32'h0);

    // Bounce shorter than the debounce window on channel 0.
    ev_seen = 0;
    for (int c = 0; c < 40; c++) begin
      sw[0] = ((c % 5) < 3);
      tick(1);
    end
    sw[0] = 1'b0;
    tick(8);
    chk("t2_stable", 32'(sw_stable), 32'h4);
    chk("t2_events", 32'(ev_seen), 32'h0);

    // Simultaneous rises on channels 3 and 1 under a stalled consumer.
    ev_ready = 1'b0;
    sw = 4'b1110;
    tick(7);
    chk("t3_valid", 32'(ev_valid), 32'h1);
    chk("t3_chan_a", 32'(ev_chan), 32'h1);
    tick(4);
    chk("t3_chan_hold", 32'(ev_chan), 32'h1);
    chk("t3_level_hold", 32'(ev_level), 32'h1);
    ev_ready = 1'b1;
    tick(1);
    chk("t3_valid_b", 32'(ev_valid), 32'h1);
    chk("t3_chan_b", 32'(ev_chan), 32'h3);
    chk("t3_level_b", 32'(ev_level), 32'h1);
    tick(1);
    chk("t3_drained", 32'(ev_valid), 32'h0);

    // Overflow: channel 1 changes three times while its event is stuck.
    sw = 4'b0000;
    pulse_reset();
    ev_ready = 1'b0;
    sw[0] = 1'b1;
    tick(8);
    chk("t4_first", 32'(ev_chan), 32'h0);
    sw[1] = 1'b1; tick(7);
    chk("t4_no_ovf_yet", 32'(ev_overflow), 32'h0);
    sw[1] = 1'b0; tick(7);
    sw[1] = 1'b1; tick(7);
    chk("t4_ovf", 32'(ev_overflow), 32'h1);
    chk("t4_head_chan", 32'(ev_chan), 32'h0);
    chk("t4_head_level", 32'(ev_level), 32'h1);
    ev_ready = 1'b1;
    tick(1);
    chk("t4_second_chan", 32'(ev_chan), 32'h1);
    chk("t4_second_level", 32'(ev_level), 32'h1);
    tick(1);
    chk("t4_drained", 32'(ev_valid), 32'h0);

    // Reset while an event is held and a counter is mid-count.
    ev_ready = 1'b0;
    sw = 4'b1000;
    tick(7);
    chk("t5_pre_valid", 32'(ev_valid), 32'h1);
    sw = 4'b1100;
    tick(3);
    pulse_reset();
    chk("t5_stable0", 32'(sw_stable), 32'h0);
    chk("t5_valid0", 32'(ev_valid), 32'h0);
    chk("t5_chan0", 32'(ev_chan), 32'h0);
    chk("t5_ovf0", 32'(ev_overflow), 32'h0);
    tick(6);
    chk("t5_stable_new", 32'(sw_stable), 32'hC);
    chk("t5_valid_e5", 32'(ev_valid), 32'h0);
    tick(1);
    chk("t5_valid_e6", 32'(ev_valid), 32'h1);
    chk("t5_chan_e6", 32'(ev_chan), 32'h2);
    chk("t5_level_e6", 32'(ev_level), 32'h1);

    // Randomized phase: slow level changes, short glitches, random ready,
    // occasional reset; checked every cycle by the model compare.
    target = sw;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 24) == 0) target[i] = !target[i];
      end
      sw = target;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) sw[i] = !target[i];
      end
      ev_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioner for the board's slide switches and push buttons. It is the counterpart of the LED output path: raw asynchronous `sw` pins come in, and the block delivers synchronized, debounced levels, one-cycle edge pulses, and a valid/ready event stream. The event stream reports each debounced change as a channel index plus its new level. It sits directly behind the top-level pins and feeds user logic in the `clk` domain.

## Interface
- `N`, 4: number of switch channels (1..16).
- `DEBOUNCE_CYCLES`, 100000: cycles a new level must persist before acceptance (≥1); 1 ms at 100 MHz.
- `CHAN_W`, `$clog2(N)` (min 1): width of the event channel index.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  N  raw switch pins, asynchronous to `clk`.
- `sw_stable`  out  N  debounced level per channel.
- `sw_rise`  out  N  one-cycle pulse on the cycle `sw_stable[i]` goes 0→1.
- `sw_fall`  out  N  one-cycle pulse on the cycle `sw_stable[i]` goes 1→0.
- `ev_valid`  out  1  event available.
- `ev_ready`  in  1  consumer accepts the event.
- `ev_chan`  out  CHAN_W  channel index of the event.
- `ev_level`  out  1  new debounced level of that channel.
- `ev_overflow`  out  1  sticky flag: at least one unreported change was overwritten.

## Operation
- Reset values: all synchronizer stages 0, `sw_stable` 0, counters 0, `sw_rise`/`sw_fall` 0, `ev_valid` 0, `ev_chan` 0, `ev_level` 0, `ev_overflow` 0, pending bits 0.
- Reset takes priority over every other event, including mid-debounce and mid-handshake. All state is lost.
- After reset, a switch held high debounces normally and produces a rise pulse and a rise event.
- Per channel: two-flop synchronizer (`s1`, `s2`) feeds a debounce counter of width `$clog2(DEBOUNCE_CYCLES)` (min 1).
  - If `s2 == sw_stable[i]`: counter clears to 0.
  - Else, if counter == `DEBOUNCE_CYCLES-1`: `sw_stable[i]` <= `s2`, counter clears, and a rise/fall pulse is registered.
  - Else: counter increments.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `sw_stable`. The counter restarts on every bounce.
- Event path: one pending bit and one pending level per channel, plus a single output register (`ev_valid`, `ev_chan`, `ev_level`).
  - A stable change sets `pending[i]` and stores the new level.
  - Output register is free when `!ev_valid`, or when `ev_valid && ev_ready` (transfer). On any free cycle, the lowest-index pending channel is loaded and its pending bit is cleared in the same cycle.
  - Back-to-back transfers run at one per cycle.
- Handshake: once `ev_valid` is high it stays high, and `ev_chan`/`ev_level` hold constant, until a cycle with `ev_ready` high. `ev_ready` may be high while `ev_valid` is low, with no effect.
- Overflow: if channel i changes again while `pending[i]` is set and not being loaded that cycle, the pending level is overwritten with the latest level and `ev_overflow` sets.
  - Loading and a new change on the same channel in the same cycle is not overflow: the old value goes out and the new one becomes pending.
  - A change on the channel currently held in the output register is not overflow.
  - `ev_overflow` clears only on `rst`.
- Several channels may change in the same cycle. All of them set pending, and they are reported in ascending index order.

## Timing
- Take edge 0 as the first `clk` edge at which `sw[i]` samples a new level that then stays constant:
  - `s2` updates at edge 1.
  - `sw_stable[i]`, `sw_rise[i]`/`sw_fall[i]` and `pending[i]` update at edge `DEBOUNCE_CYCLES+1`.
  - With the output register free, `ev_valid` rises at edge `DEBOUNCE_CYCLES+2`.
- Rise/fall pulses are exactly one cycle wide and registered. No output depends combinationally on any input; `ev_ready` enters only the register enables.

## Structure
- Shared package `sw_debounce_pkg`: default debounce constant, `DEBOUNCE_1MS_100MHZ = 100000`, and event-record field widths. The switch and button wrappers in the top-levels reuse these.
- Sub-module `sw_debounce_chan` (synchronizer, counter, stable register, edge pulses) is generated N times. The pending bitmap, priority pick and output register live in `sw_debounce`.

## Test plan
All scenarios use N=4, DEBOUNCE_CYCLES=4.
- Reset with `sw=4'b0000`, then drive `sw[2]`=1 and hold it; `ev_ready`=1. Required: `sw_stable` becomes `4'b0100` at edge 5 with a single `sw_rise[2]` pulse at edge 5. At edge 6: `ev_valid`=1, `ev_chan`=2, `ev_level`=1, transferred in that cycle.
- Toggle `sw[0]` high for 3 cycles, low for 2 cycles, repeatedly, for 40 cycles. Required: `sw_stable[0]` stays 0, and there are no pulses and no events.
- Raise `sw[3]` and `sw[1]` in the same cycle, with `ev_ready`=0 for 10 cycles after the change. Required: event (1,1) is presented and held stable. When `ev_ready` goes to 1, event (1,1) transfers, then (3,1) on the next cycle, with no gap.
- Hold `ev_ready`=0, raise `sw[0]`, wait for its event, then raise `sw[1]`, lower `sw[1]` and raise `sw[1]` again, each held long enough to debounce. Required: `ev_overflow`=1. After the stall, the events are (0,1) then (1,1).
- Assert `rst` for one cycle while `ev_valid`=1 and a counter is mid-count. Required: all outputs are 0 on the next cycle. A switch still held high debounces anew and reports an event (chan, 1) at `DEBOUNCE_CYCLES+2` edges after its first post-reset sample.
